// File: rtl/tcb_lib_arbiter.sv
// tcb_lib_arbiter: round-robin TCB arbiter with bus locking and delayed response routing
module tcb_lib_arbiter #(
  parameter int MPN = 2,
  parameter int ABW = 32,
  parameter int DBW = 32,
  parameter int SLW = 8,
  parameter int BEW = DBW/SLW,
  parameter int DLY = 1
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MPN-1:0]           man_vld,
  input  logic [MPN-1:0]           man_lck,
  input  logic [MPN-1:0]           man_wen,
  input  logic [MPN-1:0][ABW-1:0]  man_adr,
  input  logic [MPN-1:0][BEW-1:0]  man_ben,
  input  logic [MPN-1:0][DBW-1:0]  man_wdt,
  output logic [MPN-1:0]           man_rdy,
  output logic [MPN-1:0][DBW-1:0]  man_rdt,
  output logic [MPN-1:0]           man_err,
  output logic                     sub_vld,
  output logic                     sub_lck,
  output logic                     sub_wen,
  output logic [ABW-1:0]           sub_adr,
  output logic [BEW-1:0]           sub_ben,
  output logic [DBW-1:0]           sub_wdt,
  input  logic                     sub_rdy,
  input  logic [DBW-1:0]           sub_rdt,
  input  logic                     sub_err
);
  localparam int IW = $clog2(MPN);
  typedef enum logic {ARB, LCK} state_t;
  state_t state;
  logic [IW-1:0] ptr, own, gnt, arb_gnt, cand, inc, sel_i;
  logic found, trn, sel_v;
  always_comb begin
    arb_gnt = ptr;
    cand = ptr;
    found = 1'b0;
    for (int i = 0; i < MPN; i++) begin
      cand = IW'((int'(ptr) + i) % MPN);
      if (!found && man_vld[cand]) begin
        arb_gnt = cand;
        found = 1'b1;
      end
    end
  end
  assign gnt     = (state == LCK) ? own : arb_gnt;
  assign sub_vld = rst & man_vld[gnt];
  assign sub_lck = man_lck[gnt];
  assign sub_wen = man_wen[gnt];
  assign sub_adr = man_adr[gnt];
  assign sub_ben = man_ben[gnt];
  assign sub_wdt = man_wdt[gnt];
  assign man_rdy = sub_vld ? MPN'(sub_rdy) << gnt : '0;
  assign trn     = sub_vld & sub_rdy;
  assign inc     = (gnt == IW'(MPN-1)) ? '0 : gnt + 1'b1;
  // in LCK gnt equals own, so inc also serves as own+1 on unlock
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ARB;
      ptr   <= '0;
      own   <= '0;
    end else if (trn) begin
      if (state == ARB || !sub_lck) ptr <= inc;
      if (sub_lck) own <= gnt;
      state <= sub_lck ? LCK : ARB;
    end
  if (DLY == 0) begin : g_dly0
    assign sel_v = trn;
    assign sel_i = gnt;
  end else begin : g_pipe
    logic [DLY-1:0]         pv;
    logic [DLY-1:0][IW-1:0] pi;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        pv <= '0;
        pi <= '0;
      end else begin
        pv[0] <= trn;
        pi[0] <= gnt;
        for (int k = 1; k < DLY; k++) begin
          pv[k] <= pv[k-1];
          pi[k] <= pi[k-1];
        end
      end
    assign sel_v = pv[DLY-1];
    assign sel_i = pi[DLY-1];
  end
  always_comb begin
    man_rdt = '0;
    man_err = '0;
    if (sel_v) begin
      man_rdt[sel_i] = sub_rdt;
      man_err[sel_i] = sub_err;
    end
  end
endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// tb_tcb_lib_arbiter: randomized scoreboard bench for tcb_lib_arbiter (MPN=3, DLY=2)
module tb_tcb_lib_arbiter;
  localparam int MPN = 3, ABW = 16, DBW = 32, SLW = 8, BEW = DBW/SLW, DLY = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [MPN-1:0] man_vld, man_lck, man_wen, man_rdy, man_err;
  logic [MPN-1:0][ABW-1:0] man_adr;
  logic [MPN-1:0][BEW-1:0] man_ben;
  logic [MPN-1:0][DBW-1:0] man_wdt, man_rdt;
  logic sub_vld, sub_lck, sub_wen, sub_rdy, sub_err;
  logic [ABW-1:0] sub_adr;
  logic [BEW-1:0] sub_ben;
  logic [DBW-1:0] sub_wdt, sub_rdt;
  tcb_lib_arbiter #(.MPN(MPN), .ABW(ABW), .DBW(DBW), .SLW(SLW), .BEW(BEW), .DLY(DLY)) dut (
    .clk(clk), .rst(rst), .man_vld(man_vld), .man_lck(man_lck), .man_wen(man_wen),
    .man_adr(man_adr), .man_ben(man_ben), .man_wdt(man_wdt), .man_rdy(man_rdy),
    .man_rdt(man_rdt), .man_err(man_err), .sub_vld(sub_vld), .sub_lck(sub_lck),
    .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt),
    .sub_rdy(sub_rdy), .sub_rdt(sub_rdt), .sub_err(sub_err)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; bit vld; int gnt; bit rdy; bit mux;} req_t;
  typedef struct {int due; int m;} rsp_t;
  req_t rq[$];
  rsp_t sq[$];
  int errors = 0, checks = 0, cyc = 0;
  int m_ptr = 0, m_own = 0;
  bit m_lck = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int first_req(logic [MPN-1:0] v, int from);
    for (int i = 0; i < MPN; i++)
      if (v[(from + i) % MPN]) return (from + i) % MPN;
    return -1;
  endfunction
  task automatic step(bit r, logic [MPN-1:0] v, logic [MPN-1:0] l, bit sr);
    req_t e;
    int g;
    @(posedge clk);
    cyc++;
    #1;
    rst = r;
    man_vld = v;
    man_lck = l;
    man_wen = MPN'($urandom);
    for (int m = 0; m < MPN; m++) begin
      man_adr[m] = ABW'($urandom);
      man_ben[m] = BEW'($urandom);
      man_wdt[m] = $urandom;
    end
    sub_rdy = sr;
    sub_rdt = $urandom | 32'h1;
    sub_err = ($urandom_range(0, 3) == 0);
    e = '{cyc, 1'b0, 0, 1'b0, 1'b0};
    if (!r) begin
      m_ptr = 0;
      m_own = 0;
      m_lck = 0;
      sq.delete();
    end else begin
      g = m_lck ? m_own : first_req(v, m_ptr);
      e.mux = (g >= 0);
      e.gnt = (g >= 0) ? g : 0;
      e.vld = (g >= 0) ? v[e.gnt] : 1'b0;
      e.rdy = e.vld && sr;
      if (e.rdy) begin
        sq.push_back('{cyc + DLY, g});
        if (!m_lck) begin
          m_ptr = (g + 1) % MPN;
          if (l[g]) begin m_lck = 1; m_own = g; end
        end else if (!l[g]) begin
          m_lck = 0;
          m_ptr = (g + 1) % MPN;
        end
      end
    end
    rq.push_back(e);
  endtask
  initial begin
    req_t e;
    rsp_t s;
    logic [MPN-1:0][DBW-1:0] exp_rdt;
    logic [MPN-1:0] exp_err;
    forever begin
      @(negedge clk);
      if (rq.size() == 0) continue;
      e = rq.pop_front();
      chk("cycle_align", 64'(e.cyc), 64'(cyc));
      chk("sub_vld", 64'(sub_vld), 64'(e.vld));
      chk("man_rdy", 64'(man_rdy), e.rdy ? 64'(1) << e.gnt : 64'(0));
      if (e.mux) begin
        chk("sub_adr", 64'(sub_adr), 64'(man_adr[e.gnt]));
        chk("sub_wdt", 64'(sub_wdt), 64'(man_wdt[e.gnt]));
        chk("sub_ben", 64'(sub_ben), 64'(man_ben[e.gnt]));
        chk("sub_lck", 64'(sub_lck), 64'(man_lck[e.gnt]));
        chk("sub_wen", 64'(sub_wen), 64'(man_wen[e.gnt]));
      end
      exp_rdt = '0;
      exp_err = '0;
      if (sq.size() != 0 && sq[0].due == e.cyc) begin
        s = sq.pop_front();
        exp_rdt[s.m] = sub_rdt;
        exp_err[s.m] = sub_err;
      end
      for (int m = 0; m < MPN; m++) chk($sformatf("man_rdt[%0d]", m), 64'(man_rdt[m]), 64'(exp_rdt[m]));
      chk("man_err", 64'(man_err), 64'(exp_err));
    end
  end
  initial begin
    man_vld = '0; man_lck = '0; man_wen = '0;
    man_adr = '0; man_ben = '0; man_wdt = '0;
    sub_rdy = 1'b0; sub_rdt = '0; sub_err = 1'b0;
    repeat (2) step(0, '0, '0, 1);
    step(1, 3'b010, 3'b010, 1);
    step(0, 3'b111, 3'b000, 1);
    step(1, 3'b010, 3'b000, 1);
    repeat (6) step(1, 3'b111, 3'b000, 1);
    repeat (3) step(1, 3'b001, 3'b000, 0);
    step(1, 3'b001, 3'b000, 1);
    repeat (3) step(1, 3'b111, 3'b010, 1);
    step(0, '0, '0, 1);
    step(1, 3'b100, 3'b000, 1);
    step(1, 3'b111, 3'b000, 1);
    repeat (3000)
      step($urandom_range(0, 199) != 0, MPN'($urandom), MPN'($urandom & $urandom),
           $urandom_range(0, 3) != 0);
    repeat (DLY + 2) step(1, '0, '0, 1);
    @(negedge clk);
    #1;
    chk("resp_drained", 64'(sq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
